// File: rtl/hdr_ae_pkg.sv
// Shared HDR AE definitions: bracket geometry, sequencer FSM encoding and the
// selector-index to base-shift mapping used by both selector and sequencer.
package hdr_ae_pkg;
    localparam int FRAME_IDX_W = 2;
    localparam int NUM_FRAMES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Chosen-frame index tells the sequencer how to move the bracket base.
    typedef enum logic [1:0] {
        SEL_HALF   = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_DOUBLE = 2'd2,
        SEL_QUAD   = 2'd3
    } sel_step_t;
endpackage

// File: rtl/hdr_exposure_sequencer_if.sv
// Sensor register write port: one address/data write per req/ack handshake.
interface hdr_exposure_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int EXP_W  = 16
);
    logic              reg_req;
    logic [ADDR_W-1:0] reg_addr;
    logic [EXP_W-1:0]  reg_data;
    logic              reg_ack;

    modport master (output reg_req, reg_addr, reg_data, input reg_ack);
    modport slave  (input reg_req, reg_addr, reg_data, output reg_ack);
endinterface

// File: rtl/hdr_exp_reg_master.sv
// Register write handshake: holds req with stable addr/data until ack or
// timeout, then forces one idle GAP cycle before the next write.
module hdr_exp_reg_master
    import hdr_ae_pkg::*;
#(
    parameter int                EXP_W        = 16,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] EXP_REG_ADDR = 16'h3500,
    parameter int                TIMEOUT_CYC  = 1023
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_go,
    input  logic [EXP_W-1:0]          i_data,
    input  logic                      i_err_clr,
    hdr_exposure_sequencer_if.master  bus,
    output state_t                    o_state,
    output logic                      o_err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [EXP_W-1:0] r_data;
    logic             r_err_to;
    logic             w_timeout, w_load;

    // r_cnt counts req-high cycles already elapsed; the last one ends here.
    assign w_timeout = (r_state == ST_REQ) && !bus.reg_ack &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_go) w_next = ST_REQ;
            ST_REQ:  if (bus.reg_ack || w_timeout) w_next = ST_GAP;
            ST_GAP:  w_next = i_go ? ST_REQ : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_load = (w_next == ST_REQ) && (r_state != ST_REQ);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_err_to <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) r_data <= i_data;
            r_cnt <= (r_state == ST_REQ && w_next == ST_REQ) ? r_cnt + CNT_W'(1) : '0;
            if (w_timeout)      r_err_to <= 1'b1;
            else if (i_err_clr) r_err_to <= 1'b0;
        end
    end

    assign bus.reg_req   = (r_state == ST_REQ);
    assign bus.reg_addr  = EXP_REG_ADDR;
    assign bus.reg_data  = r_data;
    assign o_state       = r_state;
    assign o_err_timeout = r_err_to;
endmodule

// File: rtl/hdr_exposure_sequencer.sv
// HDR bracket sequencer: tracks the 4-frame cycle from vsync, writes each
// upcoming frame's exposure to the sensor and recentres the base from the selector.
module hdr_exposure_sequencer
    import hdr_ae_pkg::*;
#(
    parameter int                EXP_W        = 16,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] EXP_REG_ADDR = 16'h3500,
    parameter logic [EXP_W-1:0]  EXP_INIT     = 16'h0100,
    parameter logic [EXP_W-1:0]  EXP_MIN      = 16'h0010,
    parameter logic [EXP_W-1:0]  EXP_MAX      = 16'h1FFF,
    parameter int                TIMEOUT_CYC  = 1023
) (
    input  logic                      i_pix_clk,
    input  logic                      i_reset,
    input  logic                      i_en,
    input  logic                      i_vs_in,
    input  logic                      i_sel_valid,
    input  logic [FRAME_IDX_W-1:0]    i_sel_frame,
    input  logic                      i_err_clr,
    hdr_exposure_sequencer_if.master  reg_if,
    output logic [FRAME_IDX_W-1:0]    o_frame_idx,
    output logic [EXP_W-1:0]          o_base_exp,
    output logic                      o_busy,
    output logic                      o_err_timeout,
    output logic                      o_err_overrun
);
    logic                   r_vs_d, r_pend, r_err_ovr;
    logic [FRAME_IDX_W-1:0] r_frame_idx, r_pend_tgt, w_tgt_now, w_issue_tgt;
    logic [EXP_W-1:0]       r_base, w_base_nxt, w_issue_data;
    logic [EXP_W+1:0]       w_raw;
    state_t                 w_state;
    logic w_vs_rise, w_sched, w_pend_ok, w_idle, w_gap, w_go, w_direct, w_ovr;

    assign w_vs_rise = i_vs_in & ~r_vs_d;
    assign w_sched   = w_vs_rise & i_en;
    assign w_pend_ok = r_pend & i_en;
    assign w_idle    = (w_state == ST_IDLE);
    assign w_gap     = (w_state == ST_GAP);
    // Target is the frame after the one just starting.
    assign w_tgt_now = r_frame_idx + FRAME_IDX_W'(2);

    assign w_go         = w_idle ? (w_sched | w_pend_ok) : (w_gap & w_pend_ok);
    assign w_direct     = w_idle & w_sched;
    assign w_issue_tgt  = w_direct ? w_tgt_now : r_pend_tgt;
    assign w_issue_data = r_base << w_issue_tgt;
    // A pending target is lost unless GAP is consuming it this very cycle.
    assign w_ovr        = w_sched & r_pend & ~w_gap;

    always_comb begin
        w_raw = {2'b00, r_base};
        case (sel_step_t'(i_sel_frame))
            SEL_HALF:   w_raw = {2'b00, r_base} >> 1;
            SEL_HOLD:   w_raw = {2'b00, r_base};
            SEL_DOUBLE: w_raw = {2'b00, r_base} << 1;
            SEL_QUAD:   w_raw = {2'b00, r_base} << 2;
            default:    w_raw = {2'b00, r_base};
        endcase
        if (w_raw < {2'b00, EXP_MIN})      w_base_nxt = EXP_MIN;
        else if (w_raw > {2'b00, EXP_MAX}) w_base_nxt = EXP_MAX;
        else                               w_base_nxt = w_raw[EXP_W-1:0];
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            r_vs_d      <= 1'b1;
            r_frame_idx <= '0;
            r_base      <= EXP_INIT;
            r_pend      <= 1'b0;
            r_pend_tgt  <= '0;
            r_err_ovr   <= 1'b0;
        end else begin
            r_vs_d <= i_vs_in;
            if (w_vs_rise)   r_frame_idx <= r_frame_idx + FRAME_IDX_W'(1);
            if (i_sel_valid) r_base <= w_base_nxt;
            if (!i_en) begin
                r_pend <= 1'b0;
            end else if (w_sched && !w_idle) begin
                r_pend     <= 1'b1;
                r_pend_tgt <= w_tgt_now;
            end else if (w_go) begin
                r_pend <= 1'b0;
            end
            if (w_ovr)          r_err_ovr <= 1'b1;
            else if (i_err_clr) r_err_ovr <= 1'b0;
        end
    end

    hdr_exp_reg_master #(
        .EXP_W(EXP_W), .ADDR_W(ADDR_W),
        .EXP_REG_ADDR(EXP_REG_ADDR), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_master (
        .i_clk(i_pix_clk), .i_reset(i_reset), .i_go(w_go), .i_data(w_issue_data),
        .i_err_clr(i_err_clr), .bus(reg_if), .o_state(w_state),
        .o_err_timeout(o_err_timeout)
    );

    assign o_frame_idx   = r_frame_idx;
    assign o_base_exp    = r_base;
    assign o_busy        = ~w_idle | r_pend;
    assign o_err_overrun = r_err_ovr;
endmodule

// File: tb/tb_hdr_exposure_sequencer.sv
// Directed bench for hdr_exposure_sequencer with hand-computed expectations.
module tb_hdr_exposure_sequencer;
    logic        clk = 1'b0;
    logic        rst, en, vs, selv, clr;
    logic [1:0]  sel;
    logic [1:0]  frame_idx;
    logic [15:0] base_exp;
    logic        busy, err_to, err_ovr;
    int vectors = 0;
    int miscompares = 0;

    hdr_exposure_sequencer_if #(.ADDR_W(16), .EXP_W(16)) bus ();

    hdr_exposure_sequencer dut (
        .i_pix_clk(clk), .i_reset(rst), .i_en(en), .i_vs_in(vs),
        .i_sel_valid(selv), .i_sel_frame(sel), .i_err_clr(clr), .reg_if(bus),
        .o_frame_idx(frame_idx), .o_base_exp(base_exp), .o_busy(busy),
        .o_err_timeout(err_to), .o_err_overrun(err_ovr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse();
        vs = 1'b1; tick(); vs = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; vs = 1'b0; selv = 1'b0; sel = 2'd0; clr = 1'b0;
        bus.reg_ack = 1'b0;
        tick(); tick();
        rst = 1'b0; tick();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (bus.reg_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", bus.reg_req); end
        vectors++; if (bus.reg_addr !== 16'h3500) begin miscompares++; $display("FAIL reset_addr got %h exp 3500", bus.reg_addr); end
        vectors++; if (bus.reg_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %h exp 0000", bus.reg_data); end
        vectors++; if (frame_idx !== 2'd0) begin miscompares++; $display("FAIL reset_frame got %0d exp 0", frame_idx); end
        vectors++; if (base_exp !== 16'h0100) begin miscompares++; $display("FAIL reset_base got %h exp 0100", base_exp); end
        vectors++; if ({busy, err_to, err_ovr} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {busy, err_to, err_ovr}); end
    endtask

    task automatic test_bracket();
        logic [15:0] exp_d [4] = '{16'h0400, 16'h0800, 16'h0100, 16'h0200};
        logic [1:0]  exp_f [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        en = 1'b1; tick();
        for (int k = 0; k < 4; k++) begin
            pulse();
            vectors++; if (bus.reg_req !== 1'b1) begin miscompares++; $display("FAIL bracket_req%0d got %b exp 1", k, bus.reg_req); end
            vectors++; if (frame_idx !== exp_f[k]) begin miscompares++; $display("FAIL bracket_frame%0d got %0d exp %0d", k, frame_idx, exp_f[k]); end
            vectors++; if (bus.reg_data !== exp_d[k]) begin miscompares++; $display("FAIL bracket_data%0d got %h exp %h", k, bus.reg_data, exp_d[k]); end
            tick(); tick();
            bus.reg_ack = 1'b1; tick(); bus.reg_ack = 1'b0;
            vectors++; if (bus.reg_req !== 1'b0) begin miscompares++; $display("FAIL bracket_gap%0d got %b exp 0", k, bus.reg_req); end
            tick();
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bracket_idle%0d got %b exp 0", k, busy); end
        end
    endtask

    task automatic test_base_update();
        logic [1:0]  s [16] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0,
                                2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [15:0] e [16] = '{16'h0080, 16'h0100, 16'h0400, 16'h0800, 16'h1FFF, 16'h1FFF,
                                16'h0FFF, 16'h07FF, 16'h03FF, 16'h01FF, 16'h00FF, 16'h007F,
                                16'h003F, 16'h001F, 16'h0010, 16'h0010};
        apply_reset();
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sel = s[k]; selv = 1'b1; tick(); selv = 1'b0;
            vectors++; if (base_exp !== e[k]) begin miscompares++; $display("FAIL base_step%0d got %h exp %h", k, base_exp, e[k]); end
        end
        // Base update coincident with vsync: write uses the pre-update base.
        sel = 2'd2; selv = 1'b1; vs = 1'b1; tick(); selv = 1'b0; vs = 1'b0;
        vectors++; if (bus.reg_data !== 16'h0040) begin miscompares++; $display("FAIL base_coinc_data got %h exp 0040", bus.reg_data); end
        vectors++; if (base_exp !== 16'h0020) begin miscompares++; $display("FAIL base_coinc_base got %h exp 0020", base_exp); end
        bus.reg_ack = 1'b1; tick(); bus.reg_ack = 1'b0; tick();
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        en = 1'b1; tick();
        pulse();
        n = (bus.reg_req === 1'b1) ? 1 : 0;
        while (bus.reg_req === 1'b1 && n < 1100) begin
            tick();
            if (bus.reg_req === 1'b1) n++;
        end
        vectors++; if (n !== 1023) begin miscompares++; $display("FAIL timeout_len got %0d exp 1023", n); end
        vectors++; if (err_to !== 1'b1) begin miscompares++; $display("FAIL timeout_flag got %b exp 1", err_to); end
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        vectors++; if (err_to !== 1'b0) begin miscompares++; $display("FAIL timeout_clr got %b exp 0", err_to); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        en = 1'b1; tick();
        pulse(); tick();
        pulse(); tick();
        pulse(); tick();
        vectors++; if (err_ovr !== 1'b1) begin miscompares++; $display("FAIL b2b_overrun got %b exp 1", err_ovr); end
        vectors++; if (bus.reg_data !== 16'h0400 || bus.reg_req !== 1'b1) begin miscompares++; $display("FAIL b2b_first got %b/%h exp 1/0400", bus.reg_req, bus.reg_data); end
        vectors++; if (frame_idx !== 2'd3) begin miscompares++; $display("FAIL b2b_frame got %0d exp 3", frame_idx); end
        bus.reg_ack = 1'b1; tick(); bus.reg_ack = 1'b0;
        vectors++; if (bus.reg_req !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_gap got req %b busy %b exp 0/1", bus.reg_req, busy); end
        tick();
        vectors++; if (bus.reg_req !== 1'b1 || bus.reg_data !== 16'h0100) begin miscompares++; $display("FAIL b2b_pending got %b/%h exp 1/0100", bus.reg_req, bus.reg_data); end
        bus.reg_ack = 1'b1; tick(); bus.reg_ack = 1'b0; tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done got %b exp 0", busy); end
    endtask

    task automatic test_enable_and_reset();
        logic [1:0] exp_f [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            pulse();
            vectors++; if (bus.reg_req !== 1'b0 || frame_idx !== exp_f[k]) begin miscompares++; $display("FAIL en_off%0d got req %b frame %0d exp 0/%0d", k, bus.reg_req, frame_idx, exp_f[k]); end
            tick();
        end
        // en falls with a write in flight and one pending.
        en = 1'b1;
        pulse(); tick(); pulse(); en = 1'b0; tick();
        bus.reg_ack = 1'b1; tick(); bus.reg_ack = 1'b0; tick();
        vectors++; if (bus.reg_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL en_fall got req %b busy %b exp 0/0", bus.reg_req, busy); end
        // Reset mid-REQ with modified base and frame.
        en = 1'b1; sel = 2'd2; selv = 1'b1; tick(); selv = 1'b0;
        pulse();
        vectors++; if (bus.reg_req !== 1'b1) begin miscompares++; $display("FAIL midreset_pre got %b exp 1", bus.reg_req); end
        rst = 1'b1; tick();
        vectors++; if (bus.reg_req !== 1'b0 || bus.reg_data !== 16'h0000) begin miscompares++; $display("FAIL midreset_bus got %b/%h exp 0/0000", bus.reg_req, bus.reg_data); end
        vectors++; if (frame_idx !== 2'd0 || base_exp !== 16'h0100) begin miscompares++; $display("FAIL midreset_state got %0d/%h exp 0/0100", frame_idx, base_exp); end
        vectors++; if ({busy, err_to, err_ovr} !== 3'b000) begin miscompares++; $display("FAIL midreset_flags got %b exp 000", {busy, err_to, err_ovr}); end
        rst = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_bracket();
        test_base_update();
        test_timeout();
        test_back_to_back();
        test_enable_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
